// File: rtl/acc_fwd_pkg.sv
// Shared sizing and grouping-mode limits for the accumulate-and-forward pipeline.
package acc_fwd_pkg;

  localparam int DATA_W   = 16;
  localparam int FLAT_W   = 1024;
  localparam int DEPTH    = 12;
  localparam int MODE_MIN = 3;
  localparam int MODE_MAX = 13;

endpackage

// File: rtl/pipe_delay.sv
// Enable-gated, asynchronously cleared shift register used for every bypass path.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/acc_forwarding.sv
// Accumulates grouped local sums and back-fills the group total into every in-flight
// slot of the forwarding pipeline, so all samples of a group leave carrying the total.
module acc_forwarding #(
  parameter int DATA_W = acc_fwd_pkg::DATA_W,
  parameter int FLAT_W = acc_fwd_pkg::FLAT_W,
  parameter int DEPTH  = acc_fwd_pkg::DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid_sum,
  input  logic [DATA_W-1:0] i_loc_sum,
  input  logic [3:0]        i_length_mode,
  input  logic [FLAT_W-1:0] i_in_flat,
  input  logic [DATA_W-1:0] i_sum64_0,
  input  logic [DATA_W-1:0] i_sum32_0,
  input  logic [DATA_W-1:0] i_sum32_1,
  input  logic [DATA_W-1:0] i_sum16_0,
  input  logic [DATA_W-1:0] i_sum16_1,
  input  logic [DATA_W-1:0] i_sum16_2,
  input  logic [DATA_W-1:0] i_sum16_3,
  output logic              o_valid_sum,
  output logic [DATA_W-1:0] o_global_sum,
  output logic [3:0]        o_length_mode_byp,
  output logic [FLAT_W-1:0] o_in_byp,
  output logic [DATA_W-1:0] o_sum64_0,
  output logic [DATA_W-1:0] o_sum32_0,
  output logic [DATA_W-1:0] o_sum32_1,
  output logic [DATA_W-1:0] o_sum16_0,
  output logic [DATA_W-1:0] o_sum16_1,
  output logic [DATA_W-1:0] o_sum16_2,
  output logic [DATA_W-1:0] o_sum16_3
);

  localparam int BYP_W = 1 + 4 + FLAT_W + 7 * DATA_W;

  logic                     grouped;
  logic [3:0]               last_idx;
  logic [DEPTH-1:0]         mask;
  logic                     grp_end;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] front;
  logic [3:0]               cnt;
  logic                     clr_flag;
  logic [DATA_W-1:0]        fwd [DEPTH];
  logic [BYP_W-1:0]         byp_d;
  logic [BYP_W-1:0]         byp_q;

  // Slots 0..mode-2 hold the current group's samples when its last sample arrives.
  always_comb begin
    grouped  = (i_length_mode >= 4'(acc_fwd_pkg::MODE_MIN)) &&
               (i_length_mode <= 4'(acc_fwd_pkg::MODE_MAX));
    last_idx = i_length_mode - 4'd2;
    mask     = '0;
    for (int k = 0; k < DEPTH; k++) mask[k] = grouped && (k < (int'(i_length_mode) - 1));
  end

  assign grp_end = grouped && i_valid_sum && (cnt == last_idx);
  assign front   = acc + $signed(i_loc_sum);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc      <= '0;
      cnt      <= '0;
      clr_flag <= 1'b0;
    end else if (i_en) begin
      if (clr_flag)         acc <= '0;
      else if (i_valid_sum) acc <= front;

      if (!i_valid_sum) begin
        cnt      <= '0;
        clr_flag <= 1'b0;
      end else if (grp_end) begin
        cnt      <= '0;
        clr_flag <= 1'b1;
      end else begin
        cnt      <= grouped ? cnt + 4'd1 : 4'd0;
        clr_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < DEPTH; k++) fwd[k] <= '0;
    end else if (i_en) begin
      fwd[0] <= (grp_end && mask[0]) ? front : i_loc_sum;
      for (int k = 1; k < DEPTH; k++) fwd[k] <= (grp_end && mask[k]) ? front : fwd[k-1];
    end
  end

  assign o_global_sum = fwd[DEPTH-1];

  assign byp_d = {i_valid_sum, i_length_mode, i_in_flat, i_sum64_0, i_sum32_0, i_sum32_1,
                  i_sum16_0, i_sum16_1, i_sum16_2, i_sum16_3};

  pipe_delay #(
    .WIDTH(BYP_W),
    .DEPTH(DEPTH)
  ) u_byp (
    .clk  (i_clk),
    .rst_n(i_rst),
    .en   (i_en),
    .d    (byp_d),
    .q    (byp_q)
  );

  assign {o_valid_sum, o_length_mode_byp, o_in_byp, o_sum64_0, o_sum32_0, o_sum32_1,
          o_sum16_0, o_sum16_1, o_sum16_2, o_sum16_3} = byp_q;

endmodule

// File: tb/tb_acc_forwarding.sv
// Directed bench for acc_forwarding: per-cycle output history checked against
// hand-computed group totals at the 12-cycle latency.
module tb_acc_forwarding;

  localparam int DATA_W = 16;
  localparam int FLAT_W = 1024;
  localparam int DEPTH  = 12;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_en = 1'b0;
  logic              i_valid_sum = 1'b0;
  logic [DATA_W-1:0] i_loc_sum = '0;
  logic [3:0]        i_length_mode = '0;
  logic [FLAT_W-1:0] i_in_flat = '0;
  logic [DATA_W-1:0] i_sum64_0 = '0, i_sum32_0 = '0, i_sum32_1 = '0;
  logic [DATA_W-1:0] i_sum16_0 = '0, i_sum16_1 = '0, i_sum16_2 = '0, i_sum16_3 = '0;
  logic              o_valid_sum;
  logic [DATA_W-1:0] o_global_sum;
  logic [3:0]        o_length_mode_byp;
  logic [FLAT_W-1:0] o_in_byp;
  logic [DATA_W-1:0] o_sum64_0, o_sum32_0, o_sum32_1;
  logic [DATA_W-1:0] o_sum16_0, o_sum16_1, o_sum16_2, o_sum16_3;

  int check_count = 0;
  int error_count = 0;

  logic              hist_valid [$];
  logic [DATA_W-1:0] hist_sum [$];
  logic [DATA_W-1:0] hist_s16 [$];
  logic [DATA_W-1:0] hist_s64 [$];
  logic [3:0]        hist_mode [$];
  logic [31:0]       hist_flat [$];

  acc_forwarding dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_en             (i_en),
    .i_valid_sum      (i_valid_sum),
    .i_loc_sum        (i_loc_sum),
    .i_length_mode    (i_length_mode),
    .i_in_flat        (i_in_flat),
    .i_sum64_0        (i_sum64_0),
    .i_sum32_0        (i_sum32_0),
    .i_sum32_1        (i_sum32_1),
    .i_sum16_0        (i_sum16_0),
    .i_sum16_1        (i_sum16_1),
    .i_sum16_2        (i_sum16_2),
    .i_sum16_3        (i_sum16_3),
    .o_valid_sum      (o_valid_sum),
    .o_global_sum     (o_global_sum),
    .o_length_mode_byp(o_length_mode_byp),
    .o_in_byp         (o_in_byp),
    .o_sum64_0        (o_sum64_0),
    .o_sum32_0        (o_sum32_0),
    .o_sum32_1        (o_sum32_1),
    .o_sum16_0        (o_sum16_0),
    .o_sum16_1        (o_sum16_1),
    .o_sum16_2        (o_sum16_2),
    .o_sum16_3        (o_sum16_3)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, then logs the outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] loc,
                               input logic [3:0] mode);
    i_en          = en;
    i_valid_sum   = valid;
    i_loc_sum     = loc;
    i_length_mode = mode;
    i_sum64_0     = loc + 16'd1000;
    i_sum32_0     = loc + 16'd2000;
    i_sum32_1     = loc + 16'd3000;
    i_sum16_0     = loc + 16'd4000;
    i_sum16_1     = loc + 16'd5000;
    i_sum16_2     = loc + 16'd6000;
    i_sum16_3     = loc ^ 16'hA5A5;
    i_in_flat         = '0;
    i_in_flat[31:0]   = {~loc, loc};
    @(posedge i_clk);
    #1;
    hist_valid.push_back(o_valid_sum);
    hist_sum.push_back(o_global_sum);
    hist_s16.push_back(o_sum16_3);
    hist_s64.push_back(o_sum64_0);
    hist_mode.push_back(o_length_mode_byp);
    hist_flat.push_back(o_in_byp[31:0]);
  endtask

  task automatic idleCycles(input int n, input logic [3:0] mode);
    repeat (n) applyStimulus(1'b1, 1'b0, 16'd0, mode);
  endtask

  task automatic startTest(input string name);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
    checkOutput({name, "_rst_valid"}, 32'(o_valid_sum), 32'd0);
    checkOutput({name, "_rst_sum"}, 32'(o_global_sum), 32'd0);
    checkOutput({name, "_rst_byp"}, 32'(o_sum16_3), 32'd0);
    i_rst = 1'b1;
    hist_valid.delete();
    hist_sum.delete();
    hist_s16.delete();
    hist_s64.delete();
    hist_mode.delete();
    hist_flat.delete();
  endtask

  initial begin
    // mode 3, group 5,6: two valid outputs carrying 11
    startTest("m3");
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd3);
    applyStimulus(1'b1, 1'b1, 16'd6, 4'd3);
    idleCycles(14, 4'd3);
    checkOutput("m3_v10", 32'(hist_valid[10]), 32'd0);
    checkOutput("m3_v11", 32'(hist_valid[11]), 32'd1);
    checkOutput("m3_v12", 32'(hist_valid[12]), 32'd1);
    checkOutput("m3_v13", 32'(hist_valid[13]), 32'd0);
    checkOutput("m3_s11", 32'(hist_sum[11]), 32'd11);
    checkOutput("m3_s12", 32'(hist_sum[12]), 32'd11);

    // mode 5, group 5..8: total 26, bypass paths delayed 12
    startTest("m5");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(5 + i), 4'd5);
    idleCycles(13, 4'd5);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("m5_sum%0d", i), 32'(hist_sum[11+i]), 32'd26);
      checkOutput($sformatf("m5_s16_%0d", i), 32'(hist_s16[11+i]), 32'(16'(5 + i) ^ 16'hA5A5));
      checkOutput($sformatf("m5_s64_%0d", i), 32'(hist_s64[11+i]), 32'(1005 + i));
      checkOutput($sformatf("m5_flat%0d", i), hist_flat[11+i], {~16'(5 + i), 16'(5 + i)});
      checkOutput($sformatf("m5_mode%0d", i), 32'(hist_mode[11+i]), 32'd5);
    end
    checkOutput("m5_v14", 32'(hist_valid[14]), 32'd1);
    checkOutput("m5_v15", 32'(hist_valid[15]), 32'd0);

    // pass-through mode 0 then a mode-3 group on top of the uncleared accumulator
    startTest("m0");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(5 + i), 4'd0);
    applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd3);
    applyStimulus(1'b1, 1'b1, 16'd6, 4'd3);
    idleCycles(14, 4'd3);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("m0_sum%0d", i), 32'(hist_sum[11+i]), 32'(5 + i));
    checkOutput("m0_v15", 32'(hist_valid[15]), 32'd0);
    checkOutput("m0_grp16", 32'(hist_sum[16]), 32'd37);
    checkOutput("m0_grp17", 32'(hist_sum[17]), 32'd37);

    // mode 13: full-depth group of 12, total 126
    startTest("m13");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 16'(5 + i), 4'd13);
    idleCycles(13, 4'd13);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("m13_sum%0d", i), 32'(hist_sum[11+i]), 32'd126);
    checkOutput("m13_v22", 32'(hist_valid[22]), 32'd1);
    checkOutput("m13_v23", 32'(hist_valid[23]), 32'd0);

    // enable held low mid-group and again while the group drains
    startTest("en");
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd5);
    applyStimulus(1'b1, 1'b1, 16'd6, 4'd5);
    repeat (3) applyStimulus(1'b0, 1'b1, 16'd100, 4'd5);
    applyStimulus(1'b1, 1'b1, 16'd7, 4'd5);
    applyStimulus(1'b1, 1'b1, 16'd8, 4'd5);
    idleCycles(8, 4'd5);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'd0, 4'd5);
    applyStimulus(1'b1, 1'b0, 16'd0, 4'd5);
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd5);
    applyStimulus(1'b1, 1'b1, 16'd6, 4'd5);
    checkOutput("en_v13", 32'(hist_valid[13]), 32'd0);
    for (int i = 14; i <= 20; i++) begin
      checkOutput($sformatf("en_sum%0d", i), 32'(hist_sum[i]), 32'd26);
      checkOutput($sformatf("en_v%0d", i), 32'(hist_valid[i]), 32'd1);
    end

    // asynchronous reset in the middle of a mode-5 group
    i_rst = 1'b0;
    #1;
    checkOutput("ar_sum", 32'(o_global_sum), 32'd0);
    checkOutput("ar_valid", 32'(o_valid_sum), 32'd0);
    checkOutput("ar_s16", 32'(o_sum16_3), 32'd0);
    checkOutput("ar_mode", 32'(o_length_mode_byp), 32'd0);
    checkOutput("ar_flat", o_in_byp[31:0], 32'd0);
    startTest("ar");
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd3);
    applyStimulus(1'b1, 1'b1, 16'd6, 4'd3);
    idleCycles(14, 4'd3);
    checkOutput("ar_s11", 32'(hist_sum[11]), 32'd11);
    checkOutput("ar_s12", 32'(hist_sum[12]), 32'd11);
    checkOutput("ar_v12", 32'(hist_valid[12]), 32'd1);
    checkOutput("ar_v13", 32'(hist_valid[13]), 32'd0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
